// File: rtl/cal_out_up.sv
// cal_out_up -- uplink packer for calculation results.
//
// Accepts per-node result beats (six 64-bit variables each), packs every
// beat into one 512-bit word using the same lane layout as the downlink
// word, buffers the words in a small FIFO and streams them out under a
// valid/ready handshake.  up_last marks the final word of a frame and done
// pulses one cycle after that word is accepted.
//
// Word layout:
//   [511:448] r_o      [447:384] alpha_o  [383:320] K_o
//   [319:256] phi_o    [255:192] pi_m_o   [191:128] psi_o
//   [127:120] node index (0-based)        [119:0]   zero
//
// Optional build macro CAL_OUT_UP_CHKSUM_EN:
//   [63:0]    XOR of the six 64-bit variable lanes of the word
//   [119:112] on the final word only: low 8 bits of the XOR of all node
//             indices of the frame
//   [119:64]  otherwise zero
// Without the macro [119:0] is zero and no checksum logic exists.

module cal_out_up #(
  parameter int FIFO_DEPTH = 4,  // power of 2, at least 2
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  // frame control
  input  logic               start,
  input  logic [CNT_W-1:0]   node_num,
  // result beats from the compute core
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [63:0]        r_o,
  input  logic [63:0]        alpha_o,
  input  logic [63:0]        K_o,
  input  logic [63:0]        phi_o,
  input  logic [63:0]        pi_m_o,
  input  logic [63:0]        psi_o,
  // packed uplink stream
  output logic [511:0]       up_data,
  output logic               up_valid,
  input  logic               up_ready,
  output logic               up_last,
  // status
  output logic               busy,
  output logic               done
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam logic [FCNT_W-1:0] FULL_LVL = FCNT_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [1:0]        state;
  logic [CNT_W-1:0]  node_num_q;   // beats expected in the current frame
  logic [CNT_W-1:0]  acc_cnt;      // beats accepted so far (next index)
  logic              done_q;

  logic [511:0]      mem_data [FIFO_DEPTH];
  logic [CNT_W-1:0]  mem_idx  [FIFO_DEPTH];  // full-width index for up_last
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FCNT_W-1:0] fifo_cnt;

`ifdef CAL_OUT_UP_CHKSUM_EN
  logic [CNT_W-1:0]  run_xor;      // XOR of indices accepted this frame
`endif

  // ---------------------------------------------------------------------
  // Handshake and status decode
  // ---------------------------------------------------------------------
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              pop_last;
  logic [CNT_W-1:0]  last_idx;
  logic [CNT_W-1:0]  head_idx;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FULL_LVL);
  assign last_idx   = node_num_q - CNT_W'(1);
  assign head_idx   = mem_idx[rd_ptr];

  // A full FIFO blocks new beats even when a pop happens in the same cycle.
  assign res_ready = (state == ST_STREAM) && !fifo_full && (acc_cnt != node_num_q);
  assign push      = res_valid && res_ready;

  assign up_valid  = !fifo_empty;
  assign up_last   = !fifo_empty && (head_idx == last_idx);
  // The storage is not reset, so an empty FIFO presents zeros instead of
  // stale entries.
  assign up_data   = fifo_empty ? '0 : mem_data[rd_ptr];

  assign pop       = up_valid && up_ready;
  assign pop_last  = pop && up_last;

  assign busy      = (state != ST_IDLE);
  assign done      = done_q;

  // ---------------------------------------------------------------------
  // Word packing for the beat currently offered
  // ---------------------------------------------------------------------
  logic [511:0] pack_word;

  // Build the 512-bit word from the current beat and its node index.
  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    pack_word          = '0;
    pack_word[511:448] = r_o;
    pack_word[447:384] = alpha_o;
    pack_word[383:320] = K_o;
    pack_word[319:256] = phi_o;
    pack_word[255:192] = pi_m_o;
    pack_word[191:128] = psi_o;
    pack_word[127:120] = 8'(acc_cnt);
`ifdef CAL_OUT_UP_CHKSUM_EN
    pack_word[63:0]    = r_o ^ alpha_o ^ K_o ^ phi_o ^ pi_m_o ^ psi_o;
    if (acc_cnt == last_idx) begin
      pack_word[119:112] = 8'(run_xor ^ acc_cnt);
    end
`endif
  end

  // ---------------------------------------------------------------------
  // Frame control FSM
  // ---------------------------------------------------------------------

  // Track frame progress: start, beat counting, drain and completion.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state      <= ST_IDLE;
      node_num_q <= '0;
      acc_cnt    <= '0;
      done_q     <= 1'b0;
`ifdef CAL_OUT_UP_CHKSUM_EN
      run_xor    <= '0;
`endif
    end else begin
      done_q <= pop_last;
      case (state)
        ST_IDLE: begin
          if (start && (node_num != '0)) begin
            state      <= ST_STREAM;
            node_num_q <= node_num;
            acc_cnt    <= '0;
`ifdef CAL_OUT_UP_CHKSUM_EN
            run_xor    <= '0;
`endif
          end
        end
        ST_STREAM: begin
          if (push) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
`ifdef CAL_OUT_UP_CHKSUM_EN
            run_xor <= run_xor ^ acc_cnt;
`endif
          end
          // With an open downstream the final word can leave before the
          // FSM would reach DRAIN; finish directly in that case.
          if (pop_last) begin
            state <= ST_IDLE;
          end else if (acc_cnt == node_num_q) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop_last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------

  // Advance pointers and occupancy on push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Write the packed word and its index into the slot at wr_ptr.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; fifo_cnt alone decides which slots are live.
    if (push) begin
      mem_data[wr_ptr] <= pack_word;
      mem_idx[wr_ptr]  <= acc_cnt;
    end
  end

endmodule
